pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush, bubble control-zeroing and a saturating back-pressure counter. It generalises the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable stage, so the CPU pipeline can stall and flush without dropping or duplicating instructions. The CPU top instantiates one per stage boundary, with control and data payload widths set per boundary.

## Interface
- CTRL_W, 3: width of control payload (e.g. WB_ctrl); forced to zero whenever the stage holds a bubble.
- DATA_W, 101: width of data payload (concatenated DM, ALU result, rd index and pc+4 at MEM/WB = 32+32+5+32).
- CNT_W, 16: width of the stall counter.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- valid_i  in  1  upstream holds a valid instruction.
- ready_o  out  1  stage can accept; equals NOT skid_valid (register-driven, no combinational path from ready_i).
- ctrl_i  in  CTRL_W  upstream control payload.
- data_i  in  DATA_W  upstream data payload.
- flush_i  in  1  kill all held and incoming entries this cycle.
- valid_o  out  1  main register holds a valid entry.
- ready_i  in  1  downstream accepts.
- ctrl_o  out  CTRL_W  control payload; 0 when valid_o=0.
- data_o  out  DATA_W  data payload; holds last value when valid_o=0.
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0, saturating.

## Operation
- Two entries: main (drives outputs) and skid. Input fires when valid_i & ready_o; output fires when valid_o & ready_i.
- Priority per edge: rst_i > flush_i > normal.
- Normal, skid valid (ready_o=0, no input accepted): on output fire, main <= skid and skid empties; otherwise hold.
- Normal, skid empty: on input fire, if main empty or output fires, main <= input; else skid <= input. With no input fire and output fire, main empties.
- A bubble is never loaded: main/skid valid bits take the source valid only.
- flush_i: main and skid valid cleared, ctrl_o cleared, input discarded (ready_o still reflects pre-flush state; the beat counts as dropped). data_o and stall_cnt_o unaffected.
- stall_cnt_o increments by 1 when valid_o & ~ready_i and holds at 2^CNT_W-1; cleared only by rst_i.
- Data order preserved: the skid entry is always older than any later input.

## Timing
- Reset values (edge with rst_i=1): valid_o=0, skid_valid=0, ready_o=1, ctrl_o=0, data_o=0, stall_cnt_o=0. Inputs in a reset cycle are discarded.
- Latency: input fire at edge N gives valid_o=1 with that payload after edge N (one cycle), when main is free.
- Throughput: 1 entry/cycle when ready_i stays 1; no bubble inserted.
- ready_i drop with main full: the next fired beat goes to skid; ready_o falls one cycle later, never combinationally.
- Simultaneous flush_i and ready_i: the flush wins; the output beat in that cycle is considered consumed by downstream (downstream must also ignore it by flush).
- Counter wrap: never; saturates.

## Structure
- Shared package cpu_pipe_pkg: widths WB_CTRL_W=3, MEM_CTRL_W, EX_CTRL_W, XLEN=32, REG_IDX_W=5, and packed struct typedefs for each stage payload so the top casts to data_i/data_o.
- One sub-module natural: pipe_sat_counter (CNT_W, enable, sync clear) for stall_cnt_o.

## Test plan
- Streaming: ready_i=1, valid_i=1 with data 1,2,3 -> data_o 1,2,3 on the three following cycles, valid_o continuous, stall_cnt_o=0.
- Back-pressure: send A, B; ready_i=0 from the cycle A appears -> B in skid, ready_o=0 next cycle; release ready_i -> outputs A then B, no loss, stall_cnt_o = stalled cycle count.
- Flush with both entries full (ctrl 3'b101) -> next cycle valid_o=0, ctrl_o=0, ready_o=1; following input C appears one cycle later alone.
- Reset mid-stall with skid full -> all outputs at reset values after one edge; valid_i=1 during reset not captured.
- Saturation with CNT_W=4: hold valid_o=1, ready_i=0 for 20 cycles -> stall_cnt_o=15 and stays.
- Bubble: valid_i=0 with ctrl_i=3'b111 -> valid_o=0, ctrl_o=0.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg
//   Shared widths and per-boundary payload layouts for the CPU pipeline.
//   The CPU top packs these structs into a pipe_stage_reg data_i and
//   unpacks data_o back into the same type at each stage boundary.
package cpu_pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_IDX_W  = 5;
  localparam int WB_CTRL_W  = 3;
  localparam int MEM_CTRL_W = 2;
  localparam int EX_CTRL_W  = 6;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_data_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc_plus4;
    logic [XLEN-1:0]      rs1_val;
    logic [XLEN-1:0]      rs2_val;
    logic [XLEN-1:0]      imm;
    logic [REG_IDX_W-1:0] rd;
  } id_ex_data_t;

  typedef struct packed {
    logic [XLEN-1:0]      alu_res;
    logic [XLEN-1:0]      store_val;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      pc_plus4;
  } ex_mem_data_t;

  typedef struct packed {
    logic [XLEN-1:0]      dm_rdata;
    logic [XLEN-1:0]      alu_res;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      pc_plus4;
  } mem_wb_data_t;

  localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clk_i   : clock, rising edge
//   clr_i   : synchronous clear, highest priority
//   en_i    : count enable
//   cnt_o   : current count
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != {CNT_W{1'b1}})) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Reusable inter-stage register with valid/ready handshake and a
//   one-entry skid buffer, so ready_o is purely registered.
//   clk_i        : clock, rising edge
//   rst_i        : synchronous reset, active-high
//   valid_i/ready_o/ctrl_i/data_i : upstream side
//   flush_i      : drop held entries and the incoming beat
//   valid_o/ready_i/ctrl_o/data_o : downstream side
//   stall_cnt_o  : saturating count of cycles with valid_o & ~ready_i
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W = WB_CTRL_W,
  parameter int DATA_W = MEM_WB_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  // Upstream only ever sees the skid occupancy, never ready_i directly.
  assign ready_o  = ~skid_valid;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = main_valid & ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush_i) begin
      // Payload registers are left alone so data_o keeps its last value.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_fire) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid || out_fire) begin
        main_valid <= 1'b1;
        main_ctrl  <= ctrl_i;
        main_data  <= data_i;
      end else begin
        skid_valid <= 1'b1;
        skid_ctrl  <= ctrl_i;
        skid_data  <= data_i;
      end
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end

  assign valid_o = main_valid;
  // A bubble must never carry live control bits downstream.
  assign ctrl_o  = main_valid ? main_ctrl : '0;
  assign data_o  = main_data;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (main_valid & ~ready_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CTRL_W = 3;
  localparam int DATA_W = 101;
  localparam int CNT_W  = 4;
  localparam int ENT_W  = CTRL_W + DATA_W;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i = '0;
  logic [DATA_W-1:0] data_i = '0;
  logic              flush_i = 1'b0;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  pipe_stage_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .ctrl_i      (ctrl_i),
    .data_i      (data_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .ctrl_o      (ctrl_o),
    .data_o      (data_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [ENT_W-1:0]  sb_q[$];
  logic [ENT_W-1:0]  sb_ent;
  logic [DATA_W-1:0] last_data = '0;
  int                exp_stall = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs while clk is low, update the scoreboard from
  // the handshake as the DUT sees it, then check outputs after the edge.
  task automatic cyc(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                     input logic rdy, input logic fl, input logic rs);
    logic [ENT_W-1:0] head;
    valid_i = v;
    ctrl_i  = c;
    data_i  = d;
    ready_i = rdy;
    flush_i = fl;
    rst_i   = rs;
    #1;
    if (!rs && !fl && valid_o && rdy && sb_q.size() > 0) begin
      head = sb_q.pop_front();
      chk("pop_ctrl", ctrl_o, head[ENT_W-1:DATA_W]);
      chk("pop_data", data_o, head[DATA_W-1:0]);
    end
    if (!rs && !fl && v && ready_o) sb_q.push_back({c, d});
    if (rs) begin
      sb_q.delete();
      exp_stall = 0;
      last_data = '0;
    end else begin
      if (fl) sb_q.delete();
      if (valid_o && !rdy && exp_stall < (2**CNT_W - 1)) exp_stall++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    chk("stall_cnt", stall_cnt_o, exp_stall);
    chk("valid_o", valid_o, sb_q.size() != 0);
    chk("ready_o", ready_o, sb_q.size() < 2);
    if (sb_q.size() != 0) begin
      head = sb_q[0];
      last_data = head[DATA_W-1:0];
      chk("ctrl_o", ctrl_o, head[ENT_W-1:DATA_W]);
    end else begin
      chk("ctrl_o_bubble", ctrl_o, 0);
    end
    chk("data_o", data_o, last_data);
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DATA_W-1:0];
  endfunction

  initial begin
    // reset
    cyc(1'b1, 3'b111, 101'h55, 1'b1, 1'b0, 1'b1);
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_data", data_o, 0);

    // streaming 1,2,3
    cyc(1'b1, 3'b001, 101'd1, 1'b1, 1'b0, 1'b0);
    chk("stream1", data_o, 1);
    cyc(1'b1, 3'b010, 101'd2, 1'b1, 1'b0, 1'b0);
    chk("stream2", data_o, 2);
    cyc(1'b1, 3'b011, 101'd3, 1'b1, 1'b0, 1'b0);
    chk("stream3", data_o, 3);
    chk("stream_valid", valid_o, 1);
    cyc(1'b0, 3'b000, 101'd0, 1'b1, 1'b0, 1'b0);
    chk("stream_stall", stall_cnt_o, 0);

    // back-pressure: A then B lands in skid
    cyc(1'b1, 3'b100, 101'hA, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 3'b110, 101'hB, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_low", ready_o, 0);
    cyc(1'b0, 3'b000, 101'd0, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_A", data_o, 101'hA);
    cyc(1'b0, 3'b000, 101'd0, 1'b1, 1'b0, 1'b0);
    chk("bp_out_B", data_o, 101'hB);
    cyc(1'b0, 3'b000, 101'd0, 1'b1, 1'b0, 1'b0);
    chk("bp_stalls", stall_cnt_o, 2);

    // flush with both entries full
    cyc(1'b1, 3'b101, 101'h11, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 3'b101, 101'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'b101, 101'h33, 1'b1, 1'b1, 1'b0);
    chk("fl_valid", valid_o, 0);
    chk("fl_ctrl", ctrl_o, 0);
    chk("fl_ready", ready_o, 1);
    cyc(1'b1, 3'b010, 101'hC, 1'b1, 1'b0, 1'b0);
    chk("fl_C", data_o, 101'hC);
    cyc(1'b0, 3'b000, 101'd0, 1'b1, 1'b0, 1'b0);

    // reset mid-stall with skid full
    cyc(1'b1, 3'b001, 101'h44, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'b001, 101'h45, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'b111, 101'h46, 1'b0, 1'b0, 1'b1);
    chk("rs_valid", valid_o, 0);
    chk("rs_ready", ready_o, 1);
    chk("rs_ctrl", ctrl_o, 0);
    chk("rs_data", data_o, 0);
    chk("rs_stall", stall_cnt_o, 0);
    cyc(1'b0, 3'b000, 101'd0, 1'b1, 1'b0, 1'b0);
    chk("rs_nocapture", valid_o, 0);

    // saturation
    cyc(1'b1, 3'b011, 101'h77, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 3'b000, 101'd0, 1'b0, 1'b0, 1'b0);
    chk("sat15", stall_cnt_o, 15);
    cyc(1'b0, 3'b000, 101'd0, 1'b0, 1'b0, 1'b0);
    chk("sat_hold", stall_cnt_o, 15);
    cyc(1'b0, 3'b000, 101'd0, 1'b1, 1'b0, 1'b0);

    // bubble
    cyc(1'b0, 3'b111, 101'h99, 1'b1, 1'b0, 1'b0);
    chk("bub_valid", valid_o, 0);
    chk("bub_ctrl", ctrl_o, 0);

    // random traffic with occasional flush
    cyc(1'b0, 3'b000, 101'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 2) != 0), 3'($urandom), rnd_data(),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0), 1'b0);
    end

    // drain
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) cyc(1'b0, 3'b000, 101'd0, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
